// File: rtl/regfile_dump.sv
// regfile_dump: walks a register range through one read port and streams
// each register as an (address, data) pair on a valid/ready interface.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 dump request, sampled only while idle
//   first_addr, last_addr inclusive range, latched on accepted start
//   rd_addr, rd_data      register-file read port (combinational data)
//   out_valid, out_ready  entry handshake
//   out_addr, out_data    current entry
//   busy                  high whenever a dump is in progress
//   done                  one-cycle pulse after the last entry is taken
module regfile_dump #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] first_addr,
    input  logic [ADDRESS_WIDTH-1:0] last_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDRESS_WIDTH-1:0] end_addr_q, end_addr_d;
    logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = READ;
                    cur_addr_d = first_addr;
                    end_addr_d = last_addr;
                end
            end
            READ: begin
                state_d    = SEND;
                out_addr_d = cur_addr_q;
                // The zero register is hardwired; ignore whatever the
                // array holds there.
                out_data_d = (cur_addr_q == '0) ? '0 : rd_data;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    if (cur_addr_q == end_addr_q) begin
                        state_d = DONE;
                    end else begin
                        // Natural overflow gives the 31 -> 0 wrap.
                        state_d    = READ;
                        cur_addr_d = cur_addr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up
        // with the state they describe.
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            end_addr_q  <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            end_addr_q  <= end_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The current address only changes on entry to READ, so it already
    // holds its last value in every other state.
    assign rd_addr   = cur_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
